// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// muldiv_unit: execute-stage multi-cycle multiply/divide engine producing the
// 64-bit {HI, LO} result for MULT, MULTU, DIV and DIVU.
//
// Ports:
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   alucontrolE  8-bit ALU op code of the E-stage instruction
//   validE       E-stage instruction is real (not a bubble)
//   flushE       kill the E-stage instruction; aborts any operation in flight
//   srcaE        rs operand (multiplicand / dividend)
//   srcbE        rt operand (multiplier / divisor)
//   stall_req    combinational; hold F/D/E while high
//   result_valid registered one-cycle pulse marking hilo_out as new
//   hilo_out     {HI, LO}: product, or {remainder, quotient}
//   state_dbg    current FSM state (IDLE=0, MUL=1, DIV_BUSY=2, DONE=3)
//
// Handshake: an op is accepted in the cycle where the unit is IDLE and a
// valid, unflushed mul/div op sits in E; stall_req stays high from that cycle
// until the result is ready. In the DONE cycle stall_req drops, result_valid
// pulses and the pipeline advances past the op, so the op still visible in E
// during DONE is never taken as a new start.
module muldiv_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  alucontrolE,
  input  logic        validE,
  input  logic        flushE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  output logic        stall_req,
  output logic        result_valid,
  output logic [63:0] hilo_out,
  output logic [1:0]  state_dbg
);

  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam int CW = $clog2(DIV_ITERS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL      = 2'd1,
    DIV_BUSY = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t state, state_n;

  // Operand / working registers. For a multiply quo_q and div_b hold the raw
  // operands; for a divide quo_q starts as |dividend| and shifts into the
  // quotient, rem_q is the partial remainder and div_b is |divisor|.
  logic [31:0]   quo_q, rem_q, div_b;
  logic [CW-1:0] counter;
  logic          mul_signed, q_neg, r_neg, div_zero;

  logic        is_mul, is_div, op_signed, start;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [32:0] shifted, trial;
  logic [63:0] ext_a, ext_b, product;
  logic [31:0] q_fix, r_fix;
  logic [63:0] div_result;
  logic        div_finish;

  assign is_mul    = (alucontrolE == EXE_MULT_OP) || (alucontrolE == EXE_MULTU_OP);
  assign is_div    = (alucontrolE == EXE_DIV_OP)  || (alucontrolE == EXE_DIVU_OP);
  assign op_signed = (alucontrolE == EXE_MULT_OP) || (alucontrolE == EXE_DIV_OP);
  assign start     = (state == IDLE) && validE && !flushE && (is_mul || is_div);

  // Gated by resetn so the stall drops the instant reset asserts, even with a
  // mul/div op sitting in E.
  assign stall_req = resetn && (start || (state == MUL) || (state == DIV_BUSY));
  assign state_dbg = state;

  assign a_neg = op_signed && srcaE[31];
  assign b_neg = op_signed && srcbE[31];
  assign abs_a = a_neg ? (~srcaE + 32'd1) : srcaE;
  assign abs_b = b_neg ? (~srcbE + 32'd1) : srcbE;

  // One restoring-division step. shifted never exceeds 2*divisor-1, so bit 32
  // of the trial difference is exactly the borrow.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, div_b};

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
  // correct for both signed and unsigned operands.
  assign ext_a   = {{32{mul_signed & quo_q[31]}}, quo_q};
  assign ext_b   = {{32{mul_signed & div_b[31]}}, div_b};
  assign product = ext_a * ext_b;

  assign q_fix      = q_neg ? (~quo_q + 32'd1) : quo_q;
  assign r_fix      = r_neg ? (~rem_q + 32'd1) : rem_q;
  // Divide by zero keeps the raw dividend in quo_q and reports it as HI.
  assign div_result = div_zero ? {quo_q, 32'hFFFF_FFFF} : {r_fix, q_fix};

  // After the last iteration one extra DIV_BUSY cycle (counter == 0) applies
  // the sign correction, keeping the negation adders out of the iteration path.
  assign div_finish = (state == DIV_BUSY) && (counter == '0);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start) state_n = is_mul ? MUL : DIV_BUSY;
      MUL:      state_n = DONE;
      DIV_BUSY: if (counter == '0) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (flushE) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      quo_q        <= '0;
      rem_q        <= '0;
      div_b        <= '0;
      counter      <= '0;
      mul_signed   <= 1'b0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      div_zero     <= 1'b0;
      hilo_out     <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state_n == DONE);
      if (start) begin
        mul_signed <= op_signed;
        q_neg      <= a_neg ^ b_neg;
        r_neg      <= a_neg;
        div_zero   <= is_div && (srcbE == 32'd0);
        rem_q      <= '0;
        if (is_mul) begin
          quo_q   <= srcaE;
          div_b   <= srcbE;
          counter <= '0;
        end else if (srcbE == 32'd0) begin
          quo_q   <= srcaE;
          div_b   <= '0;
          counter <= '0;
        end else begin
          quo_q   <= abs_a;
          div_b   <= abs_b;
          counter <= CW'(DIV_ITERS);
        end
      end else if ((state == DIV_BUSY) && (counter != '0)) begin
        rem_q   <= trial[32] ? shifted[31:0] : trial[31:0];
        quo_q   <= {quo_q[30:0], ~trial[32]};
        counter <= counter - CW'(1);
      end

      if (!flushE) begin
        if (state == MUL)  hilo_out <= product;
        else if (div_finish) hilo_out <= div_result;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
module tb_muldiv_unit;

  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
  localparam logic [7:0] OP_ADD   = 8'b00100000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  alucontrolE;
  logic        validE, flushE;
  logic [31:0] srcaE, srcbE;
  logic        stall_req, result_valid;
  logic [63:0] hilo_out;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  muldiv_unit #(.DIV_ITERS(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .alucontrolE  (alucontrolE),
    .validE       (validE),
    .flushE       (flushE),
    .srcaE        (srcaE),
    .srcbE        (srcbE),
    .stall_req    (stall_req),
    .result_valid (result_valid),
    .hilo_out     (hilo_out),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [63:0] last_hilo;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every result_valid pulse pops one expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got hilo %h expected no result_valid", hilo_out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("hilo_out", hilo_out, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; that cycle is cycle 0 of the op. The op
  // is held in E (as a stalled pipeline would) through the DONE cycle, then
  // replaced by a bubble at the start of the following cycle.
  task automatic issue(input string name, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    bit stall_ok;
    alucontrolE = op;
    srcaE       = a;
    srcbE       = b;
    validE      = 1'b1;
    exp_q.push_back(exp);
    lat      = -1;
    stall_ok = 1'b1;
    for (int cyc = 0; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        lat = cyc;
        if (stall_req !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (stall_req !== 1'b1) stall_ok = 1'b0;
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no result_valid expected one within 60 cycles", name);
      exp_q.delete();
    end else begin
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_stall"}, {63'b0, stall_ok}, 64'd1);
      last_hilo = exp;
    end
    @(posedge clk);
    #1;
    validE = 1'b0;
  endtask

  // Inputs are left as they are; the unit must stay idle for n cycles.
  task automatic idle_check(input string name, input int n);
    bit quiet;
    quiet = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (stall_req !== 1'b0) quiet = 1'b0;
    end
    check({name, "_no_stall"}, {63'b0, quiet}, 64'd1);
    check({name, "_hilo_hold"}, hilo_out, last_hilo);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn      = 1'b0;
    validE      = 1'b1;
    flushE      = 1'b0;
    alucontrolE = OP_DIV;
    srcaE       = 32'd9;
    srcbE       = 32'd3;
    last_hilo   = 64'h0;
    #12;
    check("reset_hilo", hilo_out, 64'h0);
    check("reset_valid", {63'b0, result_valid}, 64'd0);
    check("reset_stall", {63'b0, stall_req}, 64'd0);
    check("reset_state", {62'b0, state_dbg}, 64'd0);
    validE = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Divide held through DONE must not restart.
    issue("div_7_2", OP_DIV, 32'd7, 32'd2, {32'h1, 32'h3}, 34);
    idle_check("after_div", 3);

    // Back-to-back ops: each starts in the cycle after the previous DONE.
    issue("div_m7_2",   OP_DIV,   32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    issue("divu_max_1", OP_DIVU,  32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 34);
    issue("mult_m2_3",  OP_MULT,  32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 2);
    issue("multu_m2_3", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 2);
    issue("div_5_0",    OP_DIV,   32'd5, 32'd0, {32'h5, 32'hFFFF_FFFF}, 2);
    issue("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34);
    issue("div_100_m7", OP_DIV,   32'd100, 32'hFFFF_FFF9, {32'h2, 32'hFFFF_FFF2}, 34);
    issue("divu_big_2", OP_DIVU,  32'hFFFF_FFF9, 32'd2, {32'h1, 32'h7FFF_FFFC}, 34);
    issue("mult_7_m5",  OP_MULT,  32'd7, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFDD, 2);

    // Non-mul/div op and bubble with a divide code: no stall, no result.
    alucontrolE = OP_ADD;
    srcaE       = 32'd11;
    srcbE       = 32'd4;
    validE      = 1'b1;
    idle_check("add_op", 4);
    alucontrolE = OP_DIV;
    validE      = 1'b0;
    idle_check("bubble_div", 4);

    // Flush in IDLE suppresses the start.
    validE = 1'b1;
    flushE = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", {63'b0, stall_req}, 64'd0);
    @(posedge clk);
    #1;
    validE = 1'b0;
    flushE = 1'b0;
    idle_check("flush_idle", 4);

    // Flush at cycle 10 of a divide: stall low from cycle 11, no result.
    alucontrolE = OP_DIV;
    srcaE       = 32'd100;
    srcbE       = 32'd7;
    validE      = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flushE = 1'b1;
    @(posedge clk);
    #1;
    flushE = 1'b0;
    validE = 1'b0;
    @(negedge clk);
    check("flush_div_stall", {63'b0, stall_req}, 64'd0);
    check("flush_div_state", {62'b0, state_dbg}, 64'd0);
    @(posedge clk);
    #1;
    idle_check("flush_div", 40);

    // Asynchronous reset in the middle of a divide.
    alucontrolE = OP_DIV;
    srcaE       = 32'd7;
    srcbE       = 32'd2;
    validE      = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_hilo", hilo_out, 64'h0);
    check("async_rst_valid", {63'b0, result_valid}, 64'd0);
    check("async_rst_stall", {63'b0, stall_req}, 64'd0);
    check("async_rst_state", {62'b0, state_dbg}, 64'd0);
    validE    = 1'b0;
    last_hilo = 64'h0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    issue("mult_after_rst", OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2);
    idle_check("final", 3);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected end of run before 100000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
